// File: rtl/dbgu_cmd_engine.sv
// Debug-unit command engine: parses host bytes from the UART into pointer/memory/CPU-reset ops.
// Optional DBGU_ACK_EN: send 0x06 after each completed non-read command, 0x15 for unknown opcodes.
module dbgu_cmd_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned ADDR_INC       = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        dbg_mem_op,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    output logic [3:0]  dbg_wren,
    input  logic [31:0] dbg_di,
    input  logic        dbg_ready,
    output logic        cpu_n_reset,
    output logic        busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 8;

    localparam logic [BW-1:0] OP_SET_ADDR = 8'h01;
    localparam logic [BW-1:0] OP_CPU_RST  = 8'h02;
    localparam logic [BW-1:0] OP_CPU_RUN  = 8'h03;
    localparam logic [BW-1:0] OP_WRITE    = 8'h04;
    localparam logic [BW-1:0] OP_READ     = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG,
        S_MEM_WR,
        S_MEM_RD,
        S_TX,
        S_ACK
    } state_t;

`ifdef DBGU_ACK_EN
    localparam state_t DONE_ST = S_ACK;
`else
    localparam state_t DONE_ST = S_IDLE;
`endif

    state_t          state;
    state_t          state_nx;
    logic            arg_write;
    logic [1:0]      byte_cnt;
    logic [23:0]     arg_sh;
    logic [23:0]     rd_sh;
    logic [AW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            tx_hs;

    assign tx_hs   = tx_valid & tx_ready;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == AW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_SET_ADDR, OP_WRITE: state_nx = S_ARG;
                        OP_READ:               state_nx = S_MEM_RD;
                        default:               state_nx = DONE_ST;
                    endcase
                end
            end
            S_ARG: begin
                if (rx_valid) begin
                    if (byte_cnt == 2'd3) state_nx = arg_write ? S_MEM_WR : DONE_ST;
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_MEM_WR: if (dbg_ready) state_nx = DONE_ST;
            S_MEM_RD: if (dbg_ready) state_nx = S_TX;
            S_TX:     if (tx_hs && byte_cnt == 2'd3) state_nx = S_IDLE;
`ifdef DBGU_ACK_EN
            S_ACK:    if (tx_hs) state_nx = S_IDLE;
`endif
            default:  state_nx = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; memory-port controls follow the next state
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            dbg_mem_op  <= 1'b0;
            dbg_adr     <= '0;
            dbg_do      <= '0;
            dbg_wren    <= '0;
            cpu_n_reset <= 1'b1;
            busy        <= 1'b0;
            arg_write   <= 1'b0;
            byte_cnt    <= '0;
            arg_sh      <= '0;
            rd_sh       <= '0;
            tmo_cnt     <= '0;
        end else begin
            dbg_mem_op <= (state_nx == S_MEM_WR) || (state_nx == S_MEM_RD);
            dbg_wren   <= (state_nx == S_MEM_WR) ? 4'hF : 4'h0;
            busy       <= (state_nx != S_IDLE);
            tmo_cnt    <= (state == S_ARG && !rx_valid) ? tmo_cnt + AW'(1) : '0;

            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        byte_cnt  <= '0;
                        arg_write <= (rx_data == OP_WRITE);
                        if (rx_data == OP_CPU_RST) cpu_n_reset <= 1'b0;
                        if (rx_data == OP_CPU_RUN) cpu_n_reset <= 1'b1;
                    end
                end
                S_ARG: begin
                    if (rx_valid) begin
                        arg_sh   <= {rx_data, arg_sh[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (arg_write) dbg_do  <= {rx_data, arg_sh};
                            else           dbg_adr <= {rx_data, arg_sh};
                        end
                    end
                end
                S_MEM_WR: begin
                    if (dbg_ready) dbg_adr <= dbg_adr + AW'(ADDR_INC);
                end
                S_MEM_RD: begin
                    if (dbg_ready) begin
                        dbg_adr  <= dbg_adr + AW'(ADDR_INC);
                        rd_sh    <= dbg_di[31:8];
                        tx_valid <= 1'b1;
                        tx_data  <= dbg_di[7:0];
                        byte_cnt <= '0;
                    end
                end
                S_TX: begin
                    // tx_data only advances on a completed handshake
                    if (tx_hs) begin
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            tx_data  <= rd_sh[7:0];
                            rd_sh    <= {8'h00, rd_sh[23:8]};
                        end
                    end
                end
                default: ;
            endcase

`ifdef DBGU_ACK_EN
            if (state != S_ACK && state_nx == S_ACK) begin
                tx_valid <= 1'b1;
                tx_data  <= (state == S_IDLE && !(rx_data inside {[OP_SET_ADDR:OP_READ]})) ? 8'h15 : 8'h06;
            end
            if (state == S_ACK && tx_hs) tx_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_dbgu_cmd_engine.sv
// Scoreboard bench for dbgu_cmd_engine: a command-level model predicts memory ops and tx bytes.
module tb_dbgu_cmd_engine;

    localparam int unsigned TMO = 40;
    localparam int unsigned INC = 4;

    logic        clk;
    logic        n_reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_di;
    logic        dbg_ready;
    logic        cpu_n_reset;
    logic        busy;

    dbgu_cmd_engine #(.TIMEOUT_CYCLES(TMO), .ADDR_INC(INC)) dut (
        .clk(clk), .n_reset(n_reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .dbg_mem_op(dbg_mem_op), .dbg_adr(dbg_adr), .dbg_do(dbg_do), .dbg_wren(dbg_wren),
        .dbg_di(dbg_di), .dbg_ready(dbg_ready),
        .cpu_n_reset(cpu_n_reset), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  wren;
    } mem_exp_t;

    mem_exp_t    mem_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] ptr;
    logic [31:0] mdl_mem[logic [31:0]];
    logic [31:0] env_mem[logic [31:0]];
    bit          hold_ready = 0;
    int          tx_mode = 0;

    // Background contents for locations never written
    function automatic logic [31:0] fill(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory responder: random latency, one-cycle ready strobe
    bit inflight = 0;
    int lat = 0;
    initial begin
        dbg_ready = 1'b0;
        dbg_di    = '0;
        forever begin
            @(posedge clk);
            #1;
            dbg_ready = 1'b0;
            dbg_di    = $urandom;
            if (!n_reset) begin
                inflight = 0;
            end else if (dbg_mem_op && !hold_ready) begin
                if (!inflight) begin
                    inflight = 1;
                    lat = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    dbg_ready = 1'b1;
                    if (dbg_wren == 4'hF) env_mem[dbg_adr] = dbg_do;
                    else dbg_di = env_mem.exists(dbg_adr) ? env_mem[dbg_adr] : fill(dbg_adr);
                    inflight = 0;
                end else begin
                    lat--;
                end
            end
        end
    end

    // tx_ready pattern: 0 = always ready, 1 = random, 2 = three stall cycles per accept
    int stall_cnt = 0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    stall_cnt = (stall_cnt + 1) % 4;
                    tx_ready  = (stall_cnt == 3);
                end
            endcase
        end
    end

    // Memory-op monitor: checks each new request against the scoreboard
    initial begin : mem_mon
        bit       op_prev;
        mem_exp_t e;
        op_prev = 0;
        forever begin
            @(negedge clk);
            if (n_reset && dbg_mem_op && !op_prev) begin
                if (mem_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_mem_op: adr 0x%08h wren %h", dbg_adr, dbg_wren);
                end else begin
                    e = mem_q.pop_front();
                    check("mem_adr", dbg_adr, e.adr);
                    check("mem_wren", 32'(dbg_wren), 32'(e.wren));
                    if (e.wren != 4'h0) check("mem_do", dbg_do, e.data);
                end
            end
            op_prev = dbg_mem_op;
        end
    end

    // tx monitor: every accepted byte must be the next expected one
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (n_reset && tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_tx: byte 0x%02h", tx_data);
                end else begin
                    b = tx_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(b));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_ack(input logic [7:0] b);
`ifdef DBGU_ACK_EN
        tx_q.push_back(b);
`else
        if (b == 8'h00) tx_q.push_back(b);
`endif
    endtask

    task automatic cmd_set_addr(input logic [31:0] a);
        push_ack(8'h06);
        ptr = a;
        send_byte(8'h01);
        send_word(a);
    endtask

    task automatic cmd_write(input logic [31:0] d);
        mem_q.push_back('{ptr, d, 4'hF});
        push_ack(8'h06);
        mdl_mem[ptr] = d;
        ptr = ptr + INC;
        send_byte(8'h04);
        send_word(d);
    endtask

    task automatic cmd_read();
        logic [31:0] d;
        d = mdl_mem.exists(ptr) ? mdl_mem[ptr] : fill(ptr);
        mem_q.push_back('{ptr, 32'h0, 4'h0});
        for (int i = 0; i < 4; i++) tx_q.push_back(d[8*i +: 8]);
        ptr = ptr + INC;
        send_byte(8'h05);
    endtask

    task automatic cmd_cpu(input bit hold);
        push_ack(8'h06);
        send_byte(hold ? 8'h02 : 8'h03);
        @(negedge clk);
        check("cpu_n_reset", 32'(cpu_n_reset), hold ? 32'd0 : 32'd1);
    endtask

    task automatic cmd_unknown(input logic [7:0] b);
        push_ack(8'h15);
        send_byte(b);
    endtask

    // Drain the command; the exposed pointer must match the model afterwards
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || tx_q.size() != 0 || mem_q.size() != 0) && n < 4000);
        if (n >= 4000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: busy %0d, %0d tx and %0d mem expectations outstanding",
                     name, busy, tx_q.size(), mem_q.size());
            tx_q.delete();
            mem_q.delete();
        end else begin
            check({name, "_ptr"}, dbg_adr, ptr);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_mem_op"}, 32'(dbg_mem_op), 32'd0);
        check({tag, "_adr"}, dbg_adr, 32'd0);
        check({tag, "_do"}, dbg_do, 32'd0);
        check({tag, "_wren"}, 32'(dbg_wren), 32'd0);
        check({tag, "_cpu_n_reset"}, 32'(cpu_n_reset), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0]  ub;
        logic [31:0] a;
        int          r;
        n_reset  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        ptr      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        n_reset = 1'b1;

        // Write at 0x20, then read it back unstalled and with stalls
        cmd_set_addr(32'h0000_0020); wait_idle("set20");
        cmd_write(32'hAABB_CCDD);    wait_idle("wr20");
        cmd_set_addr(32'h0000_0020); wait_idle("set20b");
        cmd_read();                  wait_idle("rd20");
        tx_mode = 2;
        cmd_set_addr(32'h0000_0020); wait_idle("set20c");
        cmd_read();                  wait_idle("rd20_stall");
        tx_mode = 0;

        // Pointer wraps past the top of the address space
        cmd_set_addr(32'hFFFF_FFFC); wait_idle("settop");
        cmd_write(32'h4433_2211);    wait_idle("wrtop");

        cmd_cpu(1'b1);       wait_idle("cpu_rst");
        cmd_cpu(1'b0);       wait_idle("cpu_run");
        cmd_unknown(8'h7F);  wait_idle("unknown");

        // Reset while a read is stalled in flight
        cmd_set_addr(32'h0000_0100); wait_idle("set100");
        hold_ready = 1;
        mem_q.push_back('{ptr, 32'h0, 4'h0});
        send_byte(8'h05);
        repeat (3) @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check_reset_values("midop");
        ptr = '0;
        @(posedge clk);
        #1;
        hold_ready = 0;
        n_reset    = 1'b1;
        cmd_read(); wait_idle("rd_after_rst");

        // Partial SET_ADDR aborted by silence; pointer stays where it was
        ptr = '0;
        cmd_set_addr(32'h0000_0000); wait_idle("set0");
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h00);
        repeat (TMO + 5) @(posedge clk);
        @(negedge clk);
        check("tmo_busy", 32'(busy), 32'd0);
        cmd_read(); wait_idle("rd_after_tmo");

        // Randomized command mix
        tx_mode = 1;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                case ($urandom_range(0, 2))
                    0: a = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4;
                    1: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
                    default: a = $urandom;
                endcase
                cmd_set_addr(a);
            end else if (r < 5) begin
                cmd_write($urandom);
            end else if (r < 8) begin
                cmd_read();
            end else if (r == 8) begin
                cmd_cpu(1'($urandom_range(0, 1)));
            end else begin
                do ub = 8'($urandom); while (ub >= 8'h01 && ub <= 8'h05);
                cmd_unknown(ub);
            end
            wait_idle("rand");
        end

        check("tx_q_drained", 32'(tx_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dbgu_cmd_engine.md
Name: dbgu_cmd_engine

Overview:
- Debug-unit command engine sitting directly downstream of the debug UART byte receiver.
- Parses the host command byte stream: set address pointer, write word, read word, CPU reset control.
- Drives the SoC debug memory port (dbg_mem_op / dbg_adr / dbg_do / dbg_wren), which takes memory from the CPU while a debug op is in flight.
- Returns read data as a little-endian byte stream to the UART transmitter.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles allowed between payload bytes before the command is aborted; 0 disables the timeout.
- ADDR_INC, 4, added to the address pointer after every completed write or read.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  byte available for the UART transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready
- dbg_mem_op  out  1  debug memory request; held until dbg_ready
- dbg_adr  out  32  byte address (current pointer)
- dbg_do  out  32  write data
- dbg_wren  out  4  byte write enables; 0 = read
- dbg_di  in  32  read data, valid in the dbg_ready cycle
- dbg_ready  in  1  one-cycle completion strobe
- cpu_n_reset  out  1  CPU reset, active low
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset values: tx_valid=0, tx_data=0, dbg_mem_op=0, dbg_adr=0, dbg_do=0, dbg_wren=0, cpu_n_reset=1, busy=0. Address pointer=0, byte counter=0, timeout counter=0.
- Reset mid-operation (any state) returns to IDLE and drops dbg_mem_op the same instant; an in-flight memory op is abandoned.
- IDLE: on rx_valid, decode rx_data:
  - 0x01 -> ARG (SET_ADDR).
  - 0x02 -> cpu_n_reset=0 next cycle, stay in IDLE.
  - 0x03 -> cpu_n_reset=1 next cycle, stay in IDLE.
  - 0x04 -> ARG (WRITE).
  - 0x05 -> MEM_RD.
  - Any other value is ignored; state stays IDLE.
- ARG: collect 4 bytes, little-endian (first byte -> bits 7:0), into a shift register; byte counter runs 0..3.
  - After the 4th byte, SET_ADDR loads the pointer and returns to IDLE.
  - After the 4th byte, WRITE loads dbg_do and goes to MEM_WR.
- Timeout: the counter restarts on every rx_valid while in ARG. When it reaches TIMEOUT_CYCLES, go to IDLE, discard partial data, leave the pointer unchanged.
- MEM_WR: dbg_mem_op=1, dbg_wren=4'hF, dbg_adr=pointer, all registered, starting the cycle after entry.
  - On dbg_ready: dbg_mem_op=0, dbg_wren=0, pointer += ADDR_INC (wraps mod 2^32), go to IDLE.
- MEM_RD: dbg_mem_op=1, dbg_wren=0. On dbg_ready: latch dbg_di, pointer += ADDR_INC, go to TX.
- TX: present 4 bytes LSB first; tx_valid stays high until 4 handshakes complete, then IDLE.
  - tx_data changes only after a completed handshake.
  - With tx_ready held high, the 4 bytes take 4 consecutive cycles.
- rx_valid in MEM_WR, MEM_RD or TX is dropped; there is no queueing. The host must wait for the response or allow worst-case latency.
- The CPU clock is never gated; memory arbitration against the CPU is external and keyed on dbg_mem_op.

Optional Feature:
- Macro DBGU_ACK_EN.
- Defined: a new ACK state sends byte 0x06 via the tx handshake after each completed SET_ADDR, WRITE, 0x02 and 0x03 command, then returns to IDLE. Unknown opcodes send 0x15 instead.
- Undefined: no ACK state; those commands produce no tx traffic; tx is used only for read data.

Test Plan:
- Bytes 01 20 00 00 00, then 04 DD CC BB AA -> one dbg_mem_op pulse with dbg_adr=0x00000020, dbg_do=0xAABBCCDD, dbg_wren=4'hF; pointer=0x24 afterwards.
- Bytes 01 20 00 00 00, then 05, memory model returns 0xAABBCCDD -> tx bytes DD, CC, BB, AA in order; pointer=0x24. Repeat with tx_ready stalled 3 cycles per byte: same bytes, no duplicates.
- Bytes 01 20 00 then silence for TIMEOUT_CYCLES+1 cycles, then 05 -> first command aborted, pointer still 0, read issued at dbg_adr=0x0.
- Bytes 01 FC FF FF FF, then 04 11 22 33 44 -> write at 0xFFFFFFFC; pointer wraps to 0x00000000.
- Byte 02 -> cpu_n_reset=0; byte 03 -> cpu_n_reset=1; byte 0x7F -> no state change. With DBGU_ACK_EN: tx bytes 06, 06, 15.
- Assert n_reset low while in MEM_RD with dbg_ready withheld -> dbg_mem_op=0 immediately, all outputs at reset values; a following 05 completes normally.
